fantome_swarm_layer: RTL and testbench
======================================

Name: fantome_swarm_layer

Overview:
- Parametrised successor of the single teleporting ghost: one enemy fades in, holds, fades out, then teleports to a cell next to Q*bert. It repeats this for a configurable number of jumps, then exits.
- Sits beside the other sprite layers on the VGA pixel scan. It supplies per-pixel hitbox/sprite flags and ghost position to the collision and colour mixer logic.
- New relative to the previous generation: parametrised cell count, jump count, tick divider and hold time; explicit fade-in; kill request; guarded one-hot lookup; freeze also freezes the prescaler.

Parameters:
N_CELLS, 28, number of pyramid cells (width of position_qb, depth of r_xy_offset)
N_JUMPS, 6, teleports performed before the ghost exits (1..31)
TICK_DIV, 131072, clk cycles per animation tick (>=2)
HOLD_TICKS, 32, ticks spent fully visible between fades (>=1)

Ports:
clk  in  1  pixel/system clock
reset  in  1  synchronous, active-low reset
x_cnt  in  11  current scan column
y_cnt  in  10  current scan row
XDIAG_DEMI  in  11  half cube diagonal, x
XLENGTH  in  11  cube edge length, x
YDIAG_DEMI  in  10  half cube diagonal, y
e_enable_ft  in  1  spawn request, sampled in INIT
e_XY0_ft  in  21  spawn centre {x[10:0], y[9:0]}
position_qb  in  N_CELLS  one-hot Q*bert cell
r_xy_offset  in  N_CELLS x 21  per-cell origin {x, y}
freeze_power  in  1  freeze power-up active: ghost halts
kill_ft  in  1  level clear / Q*bert death: force exit
fantome_xy  out  21  ghost centre {XC, YC}
fantome_hitbox  out  1  current pixel inside ghost hitbox (registered)
le_fantome  out  1  current pixel is a drawn ghost pixel (registered)
ft_state  out  3  FSM state encoding
ft_jump_cnt  out  5  teleports completed
done_move_ft  out  1  1-cycle pulse per teleport
ft_end  out  1  1-cycle pulse when the ghost leaves

Behaviour:
- Reset (reset==0 at posedge) clears state, counters and flags:
  - state=INIT, XC=YC=0, shade=0, prescaler=0, jump_cnt=0, cell_xy=0.
  - All outputs are 0.
  - Reset mid-operation aborts immediately; no ft_end pulse is produced.
- fade_w = XDIAG_DEMI + XLENGTH, computed at 12 bits, unsigned.
- Tick: the prescaler counts 0..TICK_DIV-1 and a tick pulses on wrap. While freeze_power==1 and state!=INIT, the prescaler, shade, hold counter and state all hold.
- Cell lookup: cell_xy is registered (1-cycle latency) from r_xy_offset[i] where position_qb has exactly bit i set. For zero or multi-hot position_qb, cell_xy holds its previous value.
- FSM (ft_state encoding):
  - INIT (0): if e_enable_ft, load {XC,YC}={e_XY0_ft[20:10]-XLENGTH, e_XY0_ft[9:0]+YDIAG_DEMI}, set shade=fade_w, jump_cnt=0, then go to FADE_IN. kill_ft is ignored in INIT.
  - FADE_IN (1): on each tick, if shade!=0 then shade-- else go to HOLD with hold_cnt=0.
  - HOLD (2): on each tick, hold_cnt++. When hold_cnt==HOLD_TICKS-1 on a tick, go to FADE_OUT.
  - FADE_OUT (3): on each tick, if shade!=fade_w then shade++; else if jump_cnt==N_JUMPS go to END, else go to TELEPORT.
  - TELEPORT (4): lasts exactly one clock, with no tick needed. With d=jump_cnt[1:0], {x0,y0}=cell_xy and S=XDIAG_DEMI+XLENGTH:
    - d=0: XC=x0+S, YC=y0
    - d=1: XC=x0+S, YC=y0+2*YDIAG_DEMI
    - d=2: XC=x0-S, YC=y0
    - d=3: XC=x0-S, YC=y0+2*YDIAG_DEMI
    - Results truncate modulo 2^11 / 2^10.
    - Then jump_cnt++, pulse done_move_ft, go to FADE_IN.
  - END (5): shade is already fade_w. On the next tick, pulse ft_end, set shade=0, go to INIT.
- kill_ft==1 in any state other than INIT or END: go to FADE_OUT with jump_cnt forced to N_JUMPS, so the ghost fades from its current shade and then exits. kill_ft has priority over freeze_power.
- Pixel logic, 1-cycle registered from x_cnt/y_cnt:
  - fantome_hitbox = state!=INIT, AND XC-XDIAG_DEMI+shade <= x_cnt <= XC+XDIAG_DEMI, AND YC-XDIAG_DEMI <= y_cnt <= YC+XDIAG_DEMI.
  - le_fantome = fantome_hitbox AND (x_cnt >= XC-(XDIAG_DEMI>>1) OR |y_cnt-YC| <= YDIAG_DEMI>>1), computed in the same register stage.
- Continuous outputs: fantome_xy={XC,YC}, ft_state, and ft_jump_cnt=jump_cnt.

Test Plan:
1. Reset held 3 cycles mid-HOLD with e_enable_ft=1 -> all outputs 0, ft_state=0 on release, no ft_end.
2. Full life cycle:
   - Stimulus: TICK_DIV=2, HOLD_TICKS=2, N_JUMPS=2, XDIAG_DEMI=4, XLENGTH=2, YDIAG_DEMI=3, e_XY0_ft={100,50}; pulse e_enable_ft.
   - Required: spawn {98,53}; exactly 2 done_move_ft pulses; 1 ft_end pulse; return to INIT.
   - Required: each FADE_IN spans 7 ticks (14 clk).
3. Teleport targets: position_qb bit 5, r_xy_offset[5]={200,100}, same geometry -> first teleport {206,100}, second {206,106}.
4. freeze_power held 20 clk during FADE_IN -> shade, state and prescaler unchanged; resumes on the identical tick phase.
5. kill_ft pulse in HOLD (shade=0) -> FADE_OUT takes 7 ticks, then END, one ft_end, no done_move_ft; kill_ft together with freeze_power still exits.
6. Lookup guard: position_qb=0, then 2 bits set, during TELEPORT -> target computed from the last valid cell_xy; pixel scan across the hitbox edge with shade=3 -> fantome_hitbox rises at x_cnt=XC-1, one clk after the pixel.

Source files
------------

// File: rtl/fantome_swarm_layer.sv
// Teleporting ghost sprite layer. The ghost fades in, holds, fades out, and then
// teleports next to Q*bert. After N_JUMPS teleports it exits. It also supplies
// registered per-pixel hitbox and sprite flags.
module fantome_swarm_layer #(
  parameter int unsigned N_CELLS    = 28,
  parameter int unsigned N_JUMPS    = 6,
  parameter int unsigned TICK_DIV   = 131072,
  parameter int unsigned HOLD_TICKS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        x_cnt,
  input  logic [9:0]         y_cnt,
  input  logic [10:0]        XDIAG_DEMI,
  input  logic [10:0]        XLENGTH,
  input  logic [9:0]         YDIAG_DEMI,
  input  logic               e_enable_ft,
  input  logic [20:0]        e_XY0_ft,
  input  logic [N_CELLS-1:0] position_qb,
  input  logic [20:0]        r_xy_offset [N_CELLS],
  input  logic               freeze_power,
  input  logic               kill_ft,
  output logic [20:0]        fantome_xy,
  output logic               fantome_hitbox,
  output logic               le_fantome,
  output logic [2:0]         ft_state,
  output logic [4:0]         ft_jump_cnt,
  output logic               done_move_ft,
  output logic               ft_end
);

  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [4:0]        JUMP_MAX  = 5'(N_JUMPS);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_FADE_IN  = 3'd1,
    ST_HOLD     = 3'd2,
    ST_FADE_OUT = 3'd3,
    ST_TELEPORT = 3'd4,
    ST_END      = 3'd5
  } state_t;

  state_t            state;
  logic [10:0]       xc;
  logic [9:0]        yc;
  logic [11:0]       shade;
  logic [PRE_W-1:0]  presc;
  logic [HOLD_W-1:0] hold_cnt;
  logic [4:0]        jump_cnt;
  logic [20:0]       cell_xy;

  logic [11:0] fade_w_c;
  logic        frozen_c;
  logic        tick_c;
  logic        onehot_c;
  logic [20:0] sel_xy_c;
  logic        hit_c;
  logic        body_c;
  logic signed [13:0] px, py, cx, cy, xd, yd, sh, dy, ady;

  assign fade_w_c = 12'(XDIAG_DEMI) + 12'(XLENGTH);
  assign frozen_c = freeze_power && (state != ST_INIT);
  assign tick_c   = (presc == PRE_LAST) && !frozen_c;

  assign fantome_xy  = {xc, yc};
  assign ft_state    = state;
  assign ft_jump_cnt = jump_cnt;

  // Animation prescaler; halts while the ghost is frozen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (!frozen_c) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Guarded one-hot mux of the Q*bert cell origin.
  always_comb begin
    onehot_c = (position_qb != '0) && ((position_qb & (position_qb - 1'b1)) == '0);
    sel_xy_c = '0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (position_qb[i]) sel_xy_c = sel_xy_c | r_xy_offset[i];
    end
  end

  // Cell origin register; holds on an invalid one-hot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cell_xy <= '0;
    end else if (onehot_c) begin
      cell_xy <= sel_xy_c;
    end
  end

  // Ghost life-cycle FSM with position, shade and jump bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_INIT;
      xc           <= '0;
      yc           <= '0;
      shade        <= '0;
      hold_cnt     <= '0;
      jump_cnt     <= '0;
      done_move_ft <= 1'b0;
      ft_end       <= 1'b0;
    end else begin
      done_move_ft <= 1'b0;
      ft_end       <= 1'b0;
      if (kill_ft && (state != ST_INIT) && (state != ST_END)) begin
        state    <= ST_FADE_OUT;
        jump_cnt <= JUMP_MAX;
      end else if (!frozen_c) begin
        case (state)
          ST_INIT: begin
            if (e_enable_ft) begin
              xc       <= e_XY0_ft[20:10] - XLENGTH;
              yc       <= e_XY0_ft[9:0] + YDIAG_DEMI;
              shade    <= fade_w_c;
              jump_cnt <= '0;
              state    <= ST_FADE_IN;
            end
          end
          ST_FADE_IN: begin
            if (tick_c) begin
              if (shade != '0) begin
                shade <= shade - 1'b1;
              end else begin
                hold_cnt <= '0;
                state    <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (tick_c) begin
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_cnt == HOLD_LAST) state <= ST_FADE_OUT;
            end
          end
          ST_FADE_OUT: begin
            if (tick_c) begin
              if (shade != fade_w_c)      shade <= shade + 1'b1;
              else if (jump_cnt == JUMP_MAX) state <= ST_END;
              else                        state <= ST_TELEPORT;
            end
          end
          ST_TELEPORT: begin
            if (jump_cnt[1]) xc <= 11'(12'(cell_xy[20:10]) - fade_w_c);
            else             xc <= 11'(12'(cell_xy[20:10]) + fade_w_c);
            if (jump_cnt[0]) yc <= cell_xy[9:0] + 10'({YDIAG_DEMI, 1'b0});
            else             yc <= cell_xy[9:0];
            jump_cnt     <= jump_cnt + 1'b1;
            done_move_ft <= 1'b1;
            state        <= ST_FADE_IN;
          end
          ST_END: begin
            if (tick_c) begin
              ft_end <= 1'b1;
              shade  <= '0;
              state  <= ST_INIT;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  // Hitbox and sprite-shape tests in signed arithmetic so edges never wrap.
  always_comb begin
    px     = 14'(x_cnt);
    py     = 14'(y_cnt);
    cx     = 14'(xc);
    cy     = 14'(yc);
    xd     = 14'(XDIAG_DEMI);
    yd     = 14'(YDIAG_DEMI);
    sh     = 14'(shade);
    dy     = py - cy;
    ady    = dy[13] ? -dy : dy;
    hit_c  = (state != ST_INIT) &&
             (px >= cx - xd + sh) && (px <= cx + xd) &&
             (py >= cy - xd) && (py <= cy + xd);
    body_c = (px >= cx - (xd >>> 1)) || (ady <= (yd >>> 1));
  end

  // Registered pixel flags, one clock behind the scan counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fantome_hitbox <= 1'b0;
      le_fantome     <= 1'b0;
    end else begin
      fantome_hitbox <= hit_c;
      le_fantome     <= hit_c && body_c;
    end
  end

endmodule

// File: tb/tb_fantome_swarm_layer.sv
// Self-checking bench for fantome_swarm_layer: lockstep reference model,
// pixel vector table and directed life-cycle sequences.
module tb_fantome_swarm_layer;

  localparam int NC = 8;
  localparam int NJ = 2;
  localparam int TD = 2;
  localparam int HT = 2;
  localparam int XD = 4;
  localparam int XL = 2;
  localparam int YD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x_cnt;
  logic [9:0]    y_cnt;
  logic [10:0]   xdiag;
  logic [10:0]   xlen;
  logic [9:0]    ydiag;
  logic          en;
  logic [20:0]   exy;
  logic [NC-1:0] pos;
  logic [20:0]   offs [NC];
  logic          freeze;
  logic          kill;
  logic [20:0]   fantome_xy;
  logic          fantome_hitbox;
  logic          le_fantome;
  logic [2:0]    ft_state;
  logic [4:0]    ft_jump_cnt;
  logic          done_move_ft;
  logic          ft_end;

  always #5 clk = ~clk;

  fantome_swarm_layer #(
    .N_CELLS(NC), .N_JUMPS(NJ), .TICK_DIV(TD), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .XDIAG_DEMI(xdiag), .XLENGTH(xlen), .YDIAG_DEMI(ydiag),
    .e_enable_ft(en), .e_XY0_ft(exy), .position_qb(pos), .r_xy_offset(offs),
    .freeze_power(freeze), .kill_ft(kill), .fantome_xy(fantome_xy),
    .fantome_hitbox(fantome_hitbox), .le_fantome(le_fantome), .ft_state(ft_state),
    .ft_jump_cnt(ft_jump_cnt), .done_move_ft(done_move_ft), .ft_end(ft_end)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_end    = 0;

  // Reference model state (post-edge view)
  int m_state, m_xc, m_yc, m_shade, m_pre, m_hold, m_jump, m_cx, m_cy;
  bit m_hit, m_le, m_done, m_end;

  typedef struct {
    int ph;
    int dx;
    int dy;
    bit hit;
    bit le;
  } pix_vec_t;
  pix_vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, v, lo, hi, $time);
    end
  endtask

  // One clock of the specified behaviour, using the inputs about to be sampled.
  task automatic model_step();
    int fw, xp, yp, ady, nx, ny, ncx, ncy, idx;
    bit frz, tick;
    if (!reset) begin
      m_state = 0; m_xc = 0; m_yc = 0; m_shade = 0; m_pre = 0; m_hold = 0;
      m_jump = 0; m_cx = 0; m_cy = 0; m_hit = 0; m_le = 0; m_done = 0; m_end = 0;
      return;
    end
    fw   = int'(xdiag) + int'(xlen);
    frz  = freeze && (m_state != 0);
    tick = (m_pre == TD - 1) && !frz;
    xp   = int'(x_cnt);
    yp   = int'(y_cnt);
    ady  = yp - m_yc;
    if (ady < 0) ady = -ady;
    m_hit = (m_state != 0) && (xp >= m_xc - int'(xdiag) + m_shade) && (xp <= m_xc + int'(xdiag))
            && (yp >= m_yc - int'(xdiag)) && (yp <= m_yc + int'(xdiag));
    m_le  = m_hit && ((xp >= m_xc - int'(xdiag) / 2) || (ady <= int'(ydiag) / 2));
    ncx = m_cx; ncy = m_cy;
    if ($countones(pos) == 1) begin
      idx = 0;
      for (int i = 0; i < NC; i++) if (pos[i]) idx = i;
      ncx = int'(offs[idx][20:10]);
      ncy = int'(offs[idx][9:0]);
    end
    m_done = 0;
    m_end  = 0;
    if (kill && m_state != 0 && m_state != 5) begin
      m_state = 3;
      m_jump  = NJ;
    end else if (!frz) begin
      case (m_state)
        0: if (en) begin
          m_xc = (int'(exy[20:10]) - int'(xlen)) & 2047;
          m_yc = (int'(exy[9:0]) + int'(ydiag)) & 1023;
          m_shade = fw; m_jump = 0; m_state = 1;
        end
        1: if (tick) begin
          if (m_shade != 0) m_shade--;
          else begin m_state = 2; m_hold = 0; end
        end
        2: if (tick) begin
          m_hold++;
          if (m_hold == HT) m_state = 3;
        end
        3: if (tick) begin
          if (m_shade != fw) m_shade++;
          else if (m_jump == NJ) m_state = 5;
          else m_state = 4;
        end
        4: begin
          nx = (m_jump % 4 >= 2) ? m_cx - fw : m_cx + fw;
          ny = (m_jump % 2 == 1) ? m_cy + 2 * int'(ydiag) : m_cy;
          m_xc = nx & 2047; m_yc = ny & 1023;
          m_jump++; m_done = 1; m_state = 1;
        end
        5: if (tick) begin
          m_end = 1; m_shade = 0; m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
    if (!frz) m_pre = (m_pre + 1) % TD;
    m_cx = ncx; m_cy = ncy;
  endtask

  task automatic cyc();
    logic [32:0] act, exp;
    model_step();
    @(posedge clk);
    @(negedge clk);
    act = {ft_state, fantome_xy, ft_jump_cnt, fantome_hitbox, le_fantome, done_move_ft, ft_end};
    exp = {3'(m_state), 11'(m_xc), 10'(m_yc), 5'(m_jump), m_hit, m_le, m_done, m_end};
    chk("model_outputs", 64'(act), 64'(exp));
    if (done_move_ft) n_done++;
    if (ft_end) n_end++;
  endtask

  task automatic rnd_pix();
    x_cnt = 11'(m_xc + $urandom_range(0, 20) - 10);
    y_cnt = 10'(m_yc + $urandom_range(0, 20) - 10);
  endtask

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    while (ft_state != 3'(s) && k < budget) begin
      rnd_pix();
      cyc();
      k++;
    end
    chk("reach_state", 64'(ft_state), 64'(s));
  endtask

  task automatic spawn();
    exy = {11'd100, 10'd50};
    en  = 1'b1;
    cyc();
    en  = 1'b0;
  endtask

  task automatic run_table(input int ph);
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].ph == ph) begin
        x_cnt = 11'(98 + tbl[i].dx);
        y_cnt = 10'(53 + tbl[i].dy);
        cyc();
        chk($sformatf("pix_hit_%0d", i), 64'(fantome_hitbox), 64'(tbl[i].hit));
        chk($sformatf("pix_le_%0d", i), 64'(le_fantome), 64'(tbl[i].le));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, run, nfi, k;
    logic [20:0] tgt [$];

    // Pixel vectors around the spawn centre (98,53): ph 0 at shade 3, ph 1 at shade 0
    tbl[0]  = '{0, -2,  0, 0, 0};
    tbl[1]  = '{0, -1,  0, 1, 1};
    tbl[2]  = '{0,  0,  0, 1, 1};
    tbl[3]  = '{0,  4,  0, 1, 1};
    tbl[4]  = '{0,  5,  0, 0, 0};
    tbl[5]  = '{0, -1,  4, 1, 1};
    tbl[6]  = '{0, -1,  5, 0, 0};
    tbl[7]  = '{0, -1, -4, 1, 1};
    tbl[8]  = '{0, -1, -5, 0, 0};
    tbl[9]  = '{0,  0, -4, 1, 1};
    tbl[10] = '{0,  4,  4, 1, 1};
    tbl[11] = '{1, -4,  0, 1, 1};
    tbl[12] = '{1, -3,  2, 1, 0};
    tbl[13] = '{1, -3,  1, 1, 1};
    tbl[14] = '{1, -5,  0, 0, 0};
    tbl[15] = '{1, -4, -2, 1, 0};
    tbl[16] = '{1, -2,  3, 1, 1};
    tbl[17] = '{1, -3, -1, 1, 1};

    reset = 1'b0; x_cnt = '0; y_cnt = '0;
    xdiag = 11'(XD); xlen = 11'(XL); ydiag = 10'(YD);
    en = 1'b0; exy = '0; freeze = 1'b0; kill = 1'b0;
    pos = 8'b0010_0000;
    for (int i = 0; i < NC; i++) offs[i] = 21'($urandom);
    offs[5] = {11'd200, 10'd100};
    repeat (3) cyc();
    chk("reset_state", 64'(ft_state), 64'd0);

    // Reset held mid-HOLD aborts with no exit pulse
    reset = 1'b1;
    spawn();
    wait_state(2, 200);
    e0 = n_end;
    reset = 1'b0; en = 1'b1;
    repeat (3) cyc();
    chk("reset_outputs", 64'({ft_state, fantome_xy, ft_jump_cnt, fantome_hitbox, le_fantome,
                              done_move_ft, ft_end}), 64'd0);
    reset = 1'b1; en = 1'b0;
    cyc();
    chk("reset_release_state", 64'(ft_state), 64'd0);
    chk("reset_no_end", 64'(n_end - e0), 64'd0);

    // Full life cycle with two teleports
    d0 = n_done; e0 = n_end;
    spawn();
    chk("spawn_xy", 64'(fantome_xy), 64'({11'd98, 10'd53}));
    run = 1; nfi = 0; k = 0;
    while (n_end == e0 && k < 1500) begin
      rnd_pix();
      cyc();
      k++;
      if (ft_state == 3'd1) run++;
      else if (run > 0) begin
        chk_rng("fade_in_len", run, 13, 14);
        nfi++;
        run = 0;
      end
      if (done_move_ft) tgt.push_back(fantome_xy);
    end
    chk("life_done_count", 64'(n_done - d0), 64'd2);
    chk("life_end_count", 64'(n_end - e0), 64'd1);
    chk("life_fade_ins", 64'(nfi), 64'd3);
    chk("life_final_state", 64'(ft_state), 64'd0);
    chk("teleport_1", 64'((tgt.size() > 0) ? tgt[0] : 21'h0), 64'({11'd206, 10'd100}));
    chk("teleport_2", 64'((tgt.size() > 1) ? tgt[1] : 21'h0), 64'({11'd206, 10'd106}));

    // Freeze for 20 clocks inside FADE_IN
    spawn();
    run = 1;
    repeat (3) begin rnd_pix(); cyc(); if (ft_state == 3'd1) run++; end
    freeze = 1'b1;
    repeat (20) begin
      rnd_pix(); cyc();
      if (ft_state == 3'd1) run++;
      chk("freeze_state", 64'(ft_state), 64'd1);
    end
    chk("freeze_xy", 64'(fantome_xy), 64'({11'd98, 10'd53}));
    freeze = 1'b0;
    k = 0;
    while (ft_state == 3'd1 && k < 40) begin rnd_pix(); cyc(); k++; if (ft_state == 3'd1) run++; end
    chk_rng("freeze_fade_in_len", run, 33, 34);
    chk("freeze_next_state", 64'(ft_state), 64'd2);
    kill = 1'b1; cyc(); kill = 1'b0;
    wait_state(0, 100);

    // Kill during HOLD: fade out from shade 0, exit once, no teleport
    spawn();
    wait_state(2, 200);
    d0 = n_done; e0 = n_end;
    kill = 1'b1; cyc(); kill = 1'b0;
    chk("kill_state", 64'(ft_state), 64'd3);
    chk("kill_jump_cnt", 64'(ft_jump_cnt), 64'(NJ));
    run = 1; k = 0;
    while (ft_state == 3'd3 && k < 40) begin rnd_pix(); cyc(); k++; if (ft_state == 3'd3) run++; end
    chk_rng("kill_fade_out_len", run, 13, 14);
    chk("kill_end_state", 64'(ft_state), 64'd5);
    wait_state(0, 20);
    chk("kill_end_count", 64'(n_end - e0), 64'd1);
    chk("kill_no_done", 64'(n_done - d0), 64'd0);

    // Kill together with freeze still exits
    spawn();
    wait_state(2, 200);
    e0 = n_end;
    freeze = 1'b1; kill = 1'b1;
    cyc();
    chk("kill_freeze_state", 64'(ft_state), 64'd3);
    kill = 1'b0;
    cyc();
    chk("kill_freeze_hold", 64'(ft_state), 64'd3);
    freeze = 1'b0;
    k = 0;
    while (n_end == e0 && k < 100) begin rnd_pix(); cyc(); k++; end
    chk("kill_freeze_end", 64'(n_end - e0), 64'd1);
    chk("kill_freeze_init", 64'(ft_state), 64'd0);

    // Invalid one-hot keeps the last valid cell for the teleport
    pos = 8'b0010_0000;
    spawn();
    wait_state(3, 200);
    pos = 8'b0000_0000;
    repeat (4) begin rnd_pix(); cyc(); end
    pos = 8'b1010_0000;
    offs[7] = 21'($urandom);
    k = 0;
    while (!done_move_ft && k < 60) begin rnd_pix(); cyc(); k++; end
    chk("guard_target", 64'(fantome_xy), 64'({11'd206, 10'd100}));
    kill = 1'b1; cyc(); kill = 1'b0;
    wait_state(0, 100);

    // Pixel table: shade 3 during FADE_IN, then shade 0 in HOLD
    spawn();
    k = 0;
    while (!(m_state == 1 && m_shade == 3) && k < 60) begin rnd_pix(); cyc(); k++; end
    chk("shade3_state", 64'(ft_state), 64'd1);
    freeze = 1'b1;
    run_table(0);
    freeze = 1'b0;
    wait_state(2, 100);
    freeze = 1'b1;
    run_table(1);
    freeze = 1'b0;
    kill = 1'b1; cyc(); kill = 1'b0;
    wait_state(0, 100);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rnd_pix();
      en = ($urandom_range(0, 5) == 0);
      exy = 21'($urandom);
      if ($urandom_range(0, 30) == 0) freeze = ~freeze;
      kill = ($urandom_range(0, 150) == 0);
      reset = ($urandom_range(0, 400) != 0);
      if ($urandom_range(0, 3) != 0) pos = 8'(1) << $urandom_range(0, NC - 1);
      else pos = 8'($urandom);
      if ($urandom_range(0, 19) == 0) offs[$urandom_range(0, NC - 1)] = 21'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
